// File: rtl/meter_pkg.sv
// Shared types and helpers for the time-multiplexed peak meter.
// Sample format is s.23; magnitudes are 0.23 unsigned.
package meter_pkg;

  localparam int SW    = 24;
  localparam int MAG_W = SW - 1;

  typedef logic [MAG_W-1:0] mag_t;

  localparam mag_t MAG_MAX = 23'h7FFFFF;

  // Full-scale negative has no positive twin, so it clips.
  function automatic mag_t abs_sat(input logic [SW-1:0] d);
    mag_t m;
    mag_t r;
    m = d[MAG_W-1:0];
    r = m;
    if (d[SW-1]) begin
      if (m == '0) r = MAG_MAX;
      else r = ~m + 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/meter_rr_arb.sv
// Round-robin picker over pending channel results.
// Scans upward from the pointer; pointer moves past each grant.
module meter_rr_arb #(
  parameter int NCH = 2,
  parameter int CHW = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  input  logic           adv,
  output logic [CHW-1:0] gnt,
  output logic           gnt_vld
);

  logic [CHW-1:0] ptr;

  // Walk offsets high to low so the closest request wins.
  always_comb begin
    int j;
    gnt     = '0;
    gnt_vld = 1'b0;
    j       = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NCH) j = j - NCH;
      if (req[CHW'(j)]) begin
        gnt     = CHW'(j);
        gnt_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv) begin
      if (gnt == CHW'(NCH - 1)) ptr <= '0;
      else ptr <= gnt + 1'b1;
    end
  end

endmodule

// File: rtl/meter_sched.sv
// Shared-datapath windowed peak meter for NCH interleaved channels.
// Completed peaks queue per channel and drain round-robin.
module meter_sched #(
  parameter int NCH = 2,
  parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int SW  = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic [9:0]     size,
  input  logic           vin,
  input  logic [CHW-1:0] cin,
  input  logic [SW-1:0]  din,
  output logic           vout,
  output logic [CHW-1:0] cout,
  output logic [SW-2:0]  dout,
  input  logic           rdy,
  output logic           overrun
);

  import meter_pkg::*;

  localparam logic [CHW:0] NCH_V = (CHW + 1)'(NCH);

  mag_t           mag;
  logic           hit;
  logic           take;
  logic [CHW-1:0] gnt;
  logic           gnt_vld;

  logic [9:0]     count   [NCH];
  mag_t           peak    [NCH];
  mag_t           pending [NCH];
  logic [NCH-1:0] pend;

  assign mag  = abs_sat(din);
  assign hit  = vin && enable && ({1'b0, cin} < NCH_V);
  assign take = (!vout || rdy) && gnt_vld;

  meter_rr_arb #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (pend),
    .adv     (take),
    .gnt     (gnt),
    .gnt_vld (gnt_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        count[i]   <= '0;
        peak[i]    <= '0;
        pending[i] <= '0;
      end
      pend    <= '0;
      vout    <= 1'b0;
      cout    <= '0;
      dout    <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        if (take && gnt == CHW'(i)) pend[i] <= 1'b0;
        if (!enable) begin
          count[i] <= '0;
          peak[i]  <= '0;
        end else if (hit && cin == CHW'(i)) begin
          // Window end: current sample seeds the next window.
          if (count[i] + 10'd1 == size) begin
            count[i]   <= '0;
            pending[i] <= peak[i];
            pend[i]    <= 1'b1;
            peak[i]    <= mag;
            if (pend[i] && !(take && gnt == CHW'(i)))
              overrun <= 1'b1;
          end else begin
            count[i] <= count[i] + 10'd1;
            if (mag > peak[i]) peak[i] <= mag;
          end
        end
      end
      if (take) begin
        vout <= 1'b1;
        cout <= gnt;
        dout <= pending[gnt];
      end else if (!vout || rdy) begin
        vout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_meter_sched.sv
// Bench for meter_sched: vector table, directed corner
// sequences, then random traffic against a window-list model.
module tb_meter_sched;

  localparam int NCH = 2;
  localparam int CHW = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [9:0]  size = '0;
  logic        vin = 1'b0;
  logic [0:0]  cin = '0;
  logic [23:0] din = '0;
  logic        vout;
  logic [0:0]  cout;
  logic [22:0] dout;
  logic        rdy = 1'b0;
  logic        overrun;

  meter_sched #(.NCH(NCH), .CHW(CHW), .SW(24)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .size    (size),
    .vin     (vin),
    .cin     (cin),
    .din     (din),
    .vout    (vout),
    .cout    (cout),
    .dout    (dout),
    .rdy     (rdy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    int c;
    int d;
  } res_t;

  res_t acc[$];
  int   ov_cnt = 0;

  typedef struct {
    logic [23:0] din;
    logic [22:0] mag;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chk_res(input string nm, input int idx,
                         input int c, input int d);
    total++;
    if (idx >= acc.size()) begin
      bad++;
      $display("FAIL %s missing result #%0d (have %0d) want ch%0d %h",
               nm, idx, acc.size(), c, d);
    end else if (acc[idx].c != c || acc[idx].d != d) begin
      bad++;
      $display("FAIL %s #%0d got ch%0d %h want ch%0d %h",
               nm, idx, acc[idx].c, acc[idx].d, c, d);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int c, input logic [23:0] d);
    vin = 1'b1;
    cin = 1'(c);
    din = d;
    tick();
    vin = 1'b0;
    din = '0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    vin = 1'b0;
    rdy = 1'b0;
    enable = 1'b1;
    idle(2);
    rst_n = 1'b1;
    acc.delete();
    ov_cnt = 0;
  endtask

  // Accepted results and overrun pulses, seen away from the edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (vout && rdy) acc.push_back('{int'(cout), int'(dout)});
      if (overrun) ov_cnt++;
    end
  end

  // Reference model: windows as sample lists, results as a
  // per-channel mailbox, drained by a rotating scan.
  bit model_on = 1'b0;
  int mq[NCH][$];
  int mn[NCH];
  int mpv[NCH];
  bit mp[NCH];
  bit mv;
  int mc, md, mptr;
  bit mov;
  int m_take, m_s, m_r, m_ch;
  bit m_nov;

  function automatic int mabs(input logic [23:0] d);
    int v;
    v = int'($signed(d));
    if (v < 0) v = -v;
    if (v > 32'h7FFFFF) v = 32'h7FFFFF;
    return v;
  endfunction

  task automatic model_init();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      mn[c] = 0;
      mpv[c] = 0;
      mp[c] = 0;
    end
    mv = 0;
    mc = 0;
    md = 0;
    mptr = 0;
    mov = 0;
  endtask

  always @(negedge clk) begin
    if (model_on && rst_n) begin
      chk("m_vout", 32'(vout), 32'(mv));
      if (mv) begin
        chk("m_cout", 32'(cout), mc);
        chk("m_dout", 32'(dout), md);
      end
      chk("m_overrun", 32'(overrun), 32'(mov));
      m_take = -1;
      if (!mv || rdy) begin
        for (int k = 0; k < NCH; k++)
          if (m_take < 0 && mp[(mptr + k) % NCH]) m_take = (mptr + k) % NCH;
        if (m_take >= 0) begin
          mv = 1;
          mc = m_take;
          md = mpv[m_take];
          mp[m_take] = 0;
          mptr = (m_take + 1) % NCH;
        end else begin
          mv = 0;
        end
      end
      m_nov = 0;
      if (!enable) begin
        for (int c = 0; c < NCH; c++) begin
          mq[c].delete();
          mn[c] = 0;
        end
      end else if (vin) begin
        m_ch = int'(cin);
        m_s = (size == 0) ? 1024 : int'(size);
        mn[m_ch]++;
        if (mn[m_ch] == m_s) begin
          m_r = 0;
          for (int i = 0; i < mq[m_ch].size(); i++)
            if (mq[m_ch][i] > m_r) m_r = mq[m_ch][i];
          m_nov = mp[m_ch];
          mp[m_ch] = 1;
          mpv[m_ch] = m_r;
          mq[m_ch].delete();
          mq[m_ch].push_back(mabs(din));
          mn[m_ch] = 0;
        end else begin
          mq[m_ch].push_back(mabs(din));
        end
      end
      mov = m_nov;
    end
  end

  initial begin
    int prev;
    logic [23:0] d;
    int szs[3];

    tbl[0] = '{24'h000000, 23'h000000};
    tbl[1] = '{24'h000001, 23'h000001};
    tbl[2] = '{24'h7FFFFF, 23'h7FFFFF};
    tbl[3] = '{24'h800000, 23'h7FFFFF};
    tbl[4] = '{24'hFFFFFF, 23'h000001};
    tbl[5] = '{24'hFFFF00, 23'h000100};
    tbl[6] = '{24'h800001, 23'h7FFFFF};
    tbl[7] = '{24'h400000, 23'h400000};
    tbl[8] = '{24'hC00000, 23'h400000};
    tbl[9] = '{24'h123456, 23'h123456};

    // Reset state
    idle(1);
    chk("rst_vout", 32'(vout), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_overrun", 32'(overrun), 0);

    // Magnitude table on ch1, size=1: each result is the prior sample
    reset_dut();
    size = 10'd1;
    rdy = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      prev = (i == 0) ? 0 : int'(tbl[i-1].mag);
      send(1, (i < 10) ? tbl[i].din : 24'h0);
      tick();
      chk($sformatf("mag%0d", i), {7'd0, vout, cout, dout},
          {7'd0, 1'b1, 1'b1, 23'(prev)});
    end

    // Basic window of 4 and seeding
    reset_dut();
    size = 10'd4;
    rdy = 1'b1;
    send(0, 24'h000010);
    send(0, 24'hFFFF00);
    send(0, 24'h000005);
    send(0, 24'h000001);
    chk("win_early", 32'(vout), 0);
    tick();
    chk("win_first", {7'd0, vout, cout, dout}, {7'd0, 1'b1, 1'b0, 23'h100});
    send(0, 24'h0);
    send(0, 24'h0);
    send(0, 24'h0);
    send(0, 24'h0);
    tick();
    chk("win_seed", {7'd0, vout, cout, dout}, {7'd0, 1'b1, 1'b0, 23'h1});

    // Stall with both pending, then round-robin order
    reset_dut();
    size = 10'd2;
    send(0, 24'h11);
    send(1, 24'h22);
    send(0, 24'h0);
    send(1, 24'h0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold%0d", i), {7'd0, vout, cout, dout},
          {7'd0, 1'b1, 1'b0, 23'h11});
      tick();
    end
    rdy = 1'b1;
    tick();
    chk("b2b_ch1", {7'd0, vout, cout, dout}, {7'd0, 1'b1, 1'b1, 23'h22});
    tick();
    chk("b2b_idle", 32'(vout), 0);
    chk_res("b2b", 0, 0, 32'h11);
    chk_res("b2b", 1, 1, 32'h22);
    rdy = 1'b0;
    acc.delete();
    send(1, 24'h33);
    send(1, 24'h0);
    send(0, 24'h44);
    send(0, 24'h0);
    send(1, 24'h55);
    send(1, 24'h0);
    rdy = 1'b1;
    idle(5);
    chk("tie_n", acc.size(), 3);
    chk_res("tie", 0, 1, 32'h33);
    chk_res("tie", 1, 0, 32'h44);
    chk_res("tie", 2, 1, 32'h55);

    // Overrun: second ch0 window overwrites an unread one
    reset_dut();
    size = 10'd2;
    send(1, 24'h77);
    send(1, 24'h0);
    send(0, 24'h100);
    send(0, 24'h200);
    send(0, 24'h0);
    send(0, 24'h0);
    idle(2);
    chk("ovr_cnt", ov_cnt, 1);
    rdy = 1'b1;
    idle(4);
    chk("ovr_n", acc.size(), 2);
    chk_res("ovr", 0, 1, 32'h77);
    chk_res("ovr", 1, 0, 32'h200);

    // Window end coinciding with consume: no overrun, both delivered
    reset_dut();
    size = 10'd2;
    send(1, 24'h77);
    send(1, 24'h0);
    send(0, 24'h100);
    send(0, 24'h200);
    send(0, 24'h0);
    rdy = 1'b1;
    send(0, 24'h0);
    idle(4);
    chk("coin_ovr", ov_cnt, 0);
    chk("coin_n", acc.size(), 3);
    chk_res("coin", 1, 0, 32'h100);
    chk_res("coin", 2, 0, 32'h200);

    // Enable low mid-window; pending results still drain
    reset_dut();
    size = 10'd4;
    send(1, 24'h55);
    repeat (3) send(1, 24'h0);
    send(1, 24'h66);
    repeat (3) send(1, 24'h0);
    send(0, 24'h300);
    send(0, 24'h300);
    enable = 1'b0;
    rdy = 1'b1;
    idle(3);
    chk("en_drain_n", acc.size(), 2);
    chk_res("en_drain", 0, 1, 32'h55);
    chk_res("en_drain", 1, 1, 32'h66);
    enable = 1'b1;
    send(0, 24'h10);
    send(0, 24'h20);
    send(0, 24'h30);
    send(0, 24'h40);
    idle(3);
    chk("en_post_n", acc.size(), 3);
    chk_res("en_post", 2, 0, 32'h30);

    // Async reset with output busy and both channels pending
    reset_dut();
    size = 10'd1;
    send(0, 24'h10);
    send(1, 24'h20);
    send(0, 24'h30);
    send(1, 24'h40);
    chk("pre_rst_vout", 32'(vout), 1);
    chk("pre_rst_ovr", 32'(overrun), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vout", 32'(vout), 0);
    chk("arst_dout", 32'(dout), 0);
    chk("arst_ovr", 32'(overrun), 0);
    tick();
    rst_n = 1'b1;
    acc.delete();
    size = 10'd0;
    rdy = 1'b1;
    for (int i = 1; i <= 1023; i++) send(0, 24'(i));
    idle(3);
    chk("w1024_none", acc.size(), 0);
    send(0, 24'h0);
    idle(3);
    chk("w1024_n", acc.size(), 1);
    chk_res("w1024", 0, 0, 32'h3FF);

    // Random traffic against the model
    reset_dut();
    model_init();
    model_on = 1'b1;
    szs[0] = 3;
    szs[1] = 1;
    szs[2] = 5;
    for (int p = 0; p < 3; p++) begin
      enable = 1'b0;
      vin = 1'b0;
      tick();
      size = 10'(szs[p]);
      for (int n = 0; n < 600; n++) begin
        enable = ($urandom_range(0, 19) != 0);
        vin = ($urandom_range(0, 9) < 7);
        cin = 1'($urandom_range(0, 1));
        d = 24'($urandom());
        if ($urandom_range(0, 15) == 0) d = 24'h800000;
        din = d;
        rdy = ($urandom_range(0, 9) < 6);
        tick();
      end
    end
    vin = 1'b0;
    rdy = 1'b1;
    idle(4);
    model_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
